// File: rtl/axi4_ram_slave_if.sv
// AXI4 bus bundle shared by the RAM responder and its masters.
// Payloads are packed structs so channel fields travel together.
interface axi4 #(
    parameter int unsigned alen  = 32,
    parameter int unsigned xlen  = 32,
    parameter int unsigned idlen = 2
);
    typedef struct packed {
        logic [idlen-1:0] id;
        logic [alen-1:0]  addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } a_t;

    typedef struct packed {
        logic [xlen-1:0]   data;
        logic [xlen/8-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [idlen-1:0] id;
        logic [1:0]       resp;
    } b_t;

    typedef struct packed {
        logic [idlen-1:0] id;
        logic [xlen-1:0]  data;
        logic [1:0]       resp;
        logic             last;
    } r_t;

    a_t   aw;
    logic aw_valid;
    logic aw_ready;
    w_t   w;
    logic w_valid;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic b_ready;
    a_t   ar;
    logic ar_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
    logic r_ready;

    modport slave (
        input  aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready,
        output aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid
    );

    modport master (
        output aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready,
        input  aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid
    );
endinterface

// File: rtl/axi4_ram_slave.sv
// AXI4 responder serving bursts from a word-addressed RAM; independent
// read and write FSMs, one outstanding transaction per direction.
module axi4_ram_slave #(
    parameter int unsigned alen  = 32,
    parameter int unsigned xlen  = 32,
    parameter int unsigned idlen = 2,
    parameter int unsigned DEPTH = 1024
) (
    input logic clk,
    input logic rst,
    axi4.slave  bus
);
    localparam int unsigned SW    = xlen / 8;
    localparam int unsigned BW    = $clog2(SW);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned BYTES = DEPTH * SW;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [alen-1:0] next_addr(input logic [alen-1:0] a, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst);
        logic [alen-1:0] step;
        logic [alen-1:0] mask;
        step = alen'(1) << size;
        mask = ((alen'(len) + alen'(1)) << size) - alen'(1);
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
            default: next_addr = a + step;
        endcase
    endfunction

    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        burst_bad = (32'(size) > BW) || (burst == 2'b11) ||
                    ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic in_range(input logic [alen-1:0] a);
        in_range = a < alen'(BYTES);
    endfunction

    logic [xlen-1:0] mem [DEPTH];

    // write channel state
    w_state_t         w_state_q, w_state_d;
    logic [alen-1:0]  w_addr_q, w_addr_d;
    logic [7:0]       w_len_q, w_len_d;
    logic [2:0]       w_size_q, w_size_d;
    logic [1:0]       w_burst_q, w_burst_d;
    logic [idlen-1:0] w_id_q, w_id_d;
    logic [7:0]       w_cnt_q, w_cnt_d;
    logic             w_bad_q, w_bad_d;
    logic             w_err_q, w_err_d;
    logic             aw_ready_q, aw_ready_d;
    logic             w_ready_q, w_ready_d;
    logic             b_valid_q, b_valid_d;
    logic [idlen-1:0] b_id_q, b_id_d;
    logic [1:0]       b_resp_q, b_resp_d;

    // read channel state
    r_state_t         r_state_q, r_state_d;
    logic [alen-1:0]  r_addr_q, r_addr_d;
    logic [7:0]       r_len_q, r_len_d;
    logic [2:0]       r_size_q, r_size_d;
    logic [1:0]       r_burst_q, r_burst_d;
    logic [idlen-1:0] r_id_q, r_id_d;
    logic [7:0]       r_cnt_q, r_cnt_d;
    logic             r_bad_q, r_bad_d;
    logic             ar_ready_q, ar_ready_d;
    logic             r_valid_q, r_valid_d;
    logic [xlen-1:0]  r_data_q, r_data_d;
    logic [1:0]       r_resp_q, r_resp_d;
    logic             r_last_q, r_last_d;

    logic             we_c;
    logic             w_beat_last_c;
    logic             w_beat_err_c;
    logic [AW-1:0]    wr_idx_c;
    logic [alen-1:0]  rd_addr_c;
    logic [AW-1:0]    rd_idx_c;
    logic             rd_bad_c;
    logic             rd_ok_c;
    logic [xlen-1:0]  rd_word_c;

    assign wr_idx_c = w_addr_q[AW+BW-1:BW];

    always_comb begin
        w_state_d     = w_state_q;
        w_addr_d      = w_addr_q;
        w_len_d       = w_len_q;
        w_size_d      = w_size_q;
        w_burst_d     = w_burst_q;
        w_id_d        = w_id_q;
        w_cnt_d       = w_cnt_q;
        w_bad_d       = w_bad_q;
        w_err_d       = w_err_q;
        b_id_d        = b_id_q;
        b_resp_d      = b_resp_q;
        we_c          = 1'b0;
        w_beat_last_c = (w_cnt_q == w_len_q);
        w_beat_err_c  = w_bad_q || !in_range(w_addr_q) || (bus.w.last != w_beat_last_c);
        case (w_state_q)
            W_IDLE: begin
                if (bus.aw_valid && aw_ready_q) begin
                    w_addr_d  = bus.aw.addr;
                    w_len_d   = bus.aw.len;
                    w_size_d  = bus.aw.size;
                    w_burst_d = bus.aw.burst;
                    w_id_d    = bus.aw.id;
                    w_cnt_d   = 8'd0;
                    w_bad_d   = burst_bad(bus.aw.len, bus.aw.size, bus.aw.burst);
                    w_err_d   = w_bad_d;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.w_valid && w_ready_q) begin
                    we_c    = !w_bad_q && in_range(w_addr_q);
                    w_err_d = w_err_q || w_beat_err_c;
                    // burst length is decided by the beat count, never by w.last
                    if (w_beat_last_c) begin
                        w_state_d = W_RESP;
                        b_id_d    = w_id_q;
                        b_resp_d  = w_err_d ? SLVERR : OKAY;
                    end else begin
                        w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bus.b_ready && b_valid_q) begin
                    w_state_d = W_IDLE;
                    b_id_d    = '0;
                    b_resp_d  = OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DATA);
        b_valid_d  = (w_state_d == W_RESP);
    end

    // the beat being fetched: first beat straight from AR, later beats from the sequencer
    always_comb begin
        rd_addr_c = (r_state_q == R_IDLE) ? bus.ar.addr
                                          : next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        rd_bad_c  = (r_state_q == R_IDLE) ? burst_bad(bus.ar.len, bus.ar.size, bus.ar.burst)
                                          : r_bad_q;
        rd_idx_c  = rd_addr_c[AW+BW-1:BW];
        rd_ok_c   = !rd_bad_c && in_range(rd_addr_c);
        rd_word_c = mem[rd_idx_c];
    end

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        r_bad_d   = r_bad_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.ar_valid && ar_ready_q) begin
                    r_addr_d  = bus.ar.addr;
                    r_len_d   = bus.ar.len;
                    r_size_d  = bus.ar.size;
                    r_burst_d = bus.ar.burst;
                    r_id_d    = bus.ar.id;
                    r_cnt_d   = 8'd0;
                    r_bad_d   = rd_bad_c;
                    r_data_d  = rd_ok_c ? rd_word_c : '0;
                    r_resp_d  = rd_ok_c ? OKAY : SLVERR;
                    r_last_d  = (bus.ar.len == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_valid_q && bus.r_ready) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                        r_id_d    = '0;
                        r_data_d  = '0;
                        r_resp_d  = OKAY;
                        r_last_d  = 1'b0;
                    end else begin
                        r_addr_d = rd_addr_c;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_data_d = rd_ok_c ? rd_word_c : '0;
                        r_resp_d = rd_ok_c ? OKAY : SLVERR;
                        r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_size_q   <= '0;
            w_burst_q  <= '0;
            w_id_q     <= '0;
            w_cnt_q    <= '0;
            w_bad_q    <= 1'b0;
            w_err_q    <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= '0;
            r_state_q  <= R_IDLE;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_size_q   <= '0;
            r_burst_q  <= '0;
            r_id_q     <= '0;
            r_cnt_q    <= '0;
            r_bad_q    <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            r_last_q   <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_id_q     <= w_id_d;
            w_cnt_q    <= w_cnt_d;
            w_bad_q    <= w_bad_d;
            w_err_q    <= w_err_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            r_state_q  <= r_state_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_id_q     <= r_id_d;
            r_cnt_q    <= r_cnt_d;
            r_bad_q    <= r_bad_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
        end
    end

    // RAM is not reset; byte lanes follow the strobe as presented
    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int i = 0; i < int'(SW); i++) begin
                if (bus.w.strb[i]) begin
                    mem[wr_idx_c][i*8 +: 8] <= bus.w.data[i*8 +: 8];
                end
            end
        end
    end

    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b.id     = b_id_q;
    assign bus.b.resp   = b_resp_q;
    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r.id     = r_id_q;
    assign bus.r.data   = r_data_q;
    assign bus.r.resp   = r_resp_q;
    assign bus.r.last   = r_last_q;
endmodule

// File: tb/tb_axi4_ram_slave.sv
// Bench for axi4_ram_slave: directed and random bursts checked against a
// byte-array model of the RAM and the burst addressing/error rules.
module tb_axi4_ram_slave;
    localparam int unsigned ALEN  = 32;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDLEN = 2;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BYTES = DEPTH * 4;
    localparam int          TMO   = 300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4 #(.alen(ALEN), .xlen(XLEN), .idlen(IDLEN)) bus ();

    axi4_ram_slave #(.alen(ALEN), .xlen(XLEN), .idlen(IDLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  ref_mem [BYTES];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                              input int size, input int burst, input int beat);
        int unsigned step;
        int unsigned win;
        int unsigned base;
        step = 32'd1 << size;
        win  = (len + 1) * step;
        case (burst)
            0: return start;
            2: begin
                base = start - (start % win);
                return base + ((start - base + beat * step) % win);
            end
            default: return start + beat * step;
        endcase
    endfunction

    function automatic bit bad_burst(input int len, input int size, input int burst);
        return size > 2 || burst == 3 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic do_write(input int unsigned addr, input int len, input int size, input int burst,
                            input logic [1:0] id, input int last_at, input string tag);
        bit          err;
        bit          bad;
        int unsigned a;
        int          k;
        bad = bad_burst(len, size, burst);
        err = bad;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if ((i == len) != (i == last_at)) err = 1;
            if (a >= BYTES) err = 1;
            else if (!bad) begin
                for (int j = 0; j < 4; j++)
                    if (ws[i][j]) ref_mem[(a & ~32'd3) + j] = wd[i][j*8 +: 8];
            end
        end
        @(negedge clk);
        bus.aw.addr  = addr;
        bus.aw.len   = 8'(len);
        bus.aw.size  = 3'(size);
        bus.aw.burst = 2'(burst);
        bus.aw.id    = id;
        bus.aw_valid = 1'b1;
        k = 0;
        while (!bus.aw_ready && k < TMO) begin @(negedge clk); k++; end
        if (k >= TMO) begin check({tag, " aw timeout"}, 0, 1); bus.aw_valid = 1'b0; return; end
        @(negedge clk);
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.w.data  = wd[i];
            bus.w.strb  = ws[i];
            bus.w.last  = (i == last_at);
            bus.w_valid = 1'b1;
            k = 0;
            while (!bus.w_ready && k < TMO) begin @(negedge clk); k++; end
            if (k >= TMO) begin check({tag, " w timeout"}, 0, 1); bus.w_valid = 1'b0; return; end
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
        bus.w.last  = 1'b0;
        bus.b_ready = 1'b1;
        k = 0;
        while (!bus.b_valid && k < TMO) begin @(negedge clk); k++; end
        if (k >= TMO) begin check({tag, " b timeout"}, 0, 1); return; end
        check({tag, " b"}, {bus.b.id, bus.b.resp}, {id, err ? 2'b10 : 2'b00});
        @(negedge clk);
        check({tag, " aw_ready after b"}, bus.aw_ready, 1);
    endtask

    task automatic do_read(input int unsigned addr, input int len, input int size, input int burst,
                           input logic [1:0] id, input bit toggle, input string tag);
        bit          bad;
        bit          ok;
        int unsigned a;
        int          i;
        int          k;
        logic [31:0] d;
        bad = bad_burst(len, size, burst);
        @(negedge clk);
        bus.ar.addr  = addr;
        bus.ar.len   = 8'(len);
        bus.ar.size  = 3'(size);
        bus.ar.burst = 2'(burst);
        bus.ar.id    = id;
        bus.ar_valid = 1'b1;
        k = 0;
        while (!bus.ar_ready && k < TMO) begin @(negedge clk); k++; end
        if (k >= TMO) begin check({tag, " ar timeout"}, 0, 1); bus.ar_valid = 1'b0; return; end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        check({tag, " r_valid latency"}, bus.r_valid, 1);
        i = 0;
        k = 0;
        while (i <= len && k < 4 * TMO) begin
            bus.r_ready = toggle ? ((k % 2) == 0) : 1'b1;
            if (bus.r_valid) begin
                a  = beat_addr(addr, len, size, burst, i);
                ok = !bad && a < BYTES;
                d  = ok ? {ref_mem[(a & ~32'd3) + 3], ref_mem[(a & ~32'd3) + 2],
                           ref_mem[(a & ~32'd3) + 1], ref_mem[a & ~32'd3]} : 32'd0;
                check($sformatf("%s r beat %0d", tag, i), bus.r,
                      {id, d, ok ? 2'b00 : 2'b10, i == len});
                check({tag, " ar_ready busy"}, bus.ar_ready, 0);
                if (bus.r_ready) i++;
            end
            @(negedge clk);
            k++;
        end
        bus.r_ready = 1'b0;
        if (i <= len) check({tag, " r timeout"}, i, len + 1);
        check({tag, " idle after last"}, {bus.ar_ready, bus.r_valid}, 2'b10);
    endtask

    task automatic rand_burst(input int n);
        int unsigned addr;
        int          len;
        int          size;
        int          burst;
        int          last_at;
        for (int t = 0; t < n; t++) begin
            addr  = $urandom_range(0, BYTES + 256);
            len   = $urandom_range(0, 15);
            size  = $urandom_range(0, 3);
            burst = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len;
                do_write(addr, len, size, burst, 2'($urandom), last_at, "rand wr");
            end else begin
                do_read(addr, len, size, burst, 2'($urandom), 1'($urandom), "rand rd");
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1;
        bus.aw = '0; bus.aw_valid = 1'b0;
        bus.w  = '0; bus.w_valid  = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
        check("reset valid", {bus.b_valid, bus.r_valid}, 2'b00);
        check("reset payload", {bus.b, bus.r}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", {bus.aw_ready, bus.ar_ready, bus.w_ready}, 3'b110);

        // fill the whole RAM so every later read has a defined model value
        for (int blk = 0; blk < int'(BYTES / 64); blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(32'(blk * 64), 15, 2, 1, 2'(blk), 15, "preload");
        end

        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(32'h100, 3, 2, 1, 2'd2, 3, "incr wr");
        do_read(32'h100, 3, 2, 1, 2'd1, 1'b0, "incr rd");
        check("incr word 2", {ref_mem[32'h10B], ref_mem[32'h10A], ref_mem[32'h109], ref_mem[32'h108]},
              32'h33);
        do_read(32'h10C, 3, 2, 2, 2'd3, 1'b0, "wrap rd");
        do_read(32'h10C, 2, 2, 2, 2'd3, 1'b0, "wrap bad len");

        wd[0] = 32'h0000AB00; ws[0] = 4'h2;
        do_write(32'h201, 0, 0, 1, 2'd0, 0, "narrow wr");
        do_read(32'h200, 0, 2, 1, 2'd0, 1'b0, "narrow rd");

        do_read(32'h1000, 1, 2, 1, 2'd2, 1'b0, "oor rd");
        wd[0] = 32'hDEADBEEF; wd[1] = 32'hCAFEF00D; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h1000, 1, 2, 1, 2'd1, 1, "oor wr");
        do_read(32'h0, 1, 2, 1, 2'd1, 1'b0, "oor alias");
        do_read(32'hFFC, 1, 2, 1, 2'd0, 1'b0, "edge rd");

        do_read(32'h300, 7, 2, 1, 2'd2, 1'b1, "backpressure");

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h400, 3, 2, 1, 2'd3, 1, "early last");
        do_read(32'h400, 3, 2, 1, 2'd3, 1'b0, "early last rd");

        // reset in the middle of a stalled read burst
        @(negedge clk);
        bus.ar.addr = 32'h100; bus.ar.len = 8'd7; bus.ar.size = 3'd2;
        bus.ar.burst = 2'd1; bus.ar.id = 2'd1; bus.ar_valid = 1'b1;
        k = 0;
        while (!bus.ar_ready && k < TMO) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        @(negedge clk);
        check("mid-read r_valid", bus.r_valid, 1);
        rst = 1'b1;
        #1;
        check("rst r_valid", {bus.r_valid, bus.ar_ready}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst ready", {bus.ar_ready, bus.aw_ready, bus.r_valid}, 3'b110);
        do_read(32'h100, 3, 2, 1, 2'd0, 1'b0, "post rst rd");

        rand_burst(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
